// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz VGA timing generator: pixel/line counters with registered sync,
// blanking, coordinates and pulses. Optional frame counter: define VGA_FRAME_CNT_EN.
module vga_sync_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter logic        SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       ce,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       line_end,
   output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
   ,output logic [7:0] frame_cnt
`endif
);

   localparam logic [9:0] H_VIS_W  = 10'(H_VISIBLE);
   localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] V_VIS_W  = 10'(V_VISIBLE);
   localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
   localparam logic       SYNC_OFF = ~SYNC_POL;

   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       video_on_q, video_on_d;
   logic [9:0] pixel_x_q, pixel_x_d;
   logic [9:0] pixel_y_q, pixel_y_d;
   logic       line_end_q, line_end_d;
   logic       frame_start_q, frame_start_d;

   // Counter advance; >= on wrap keeps counters in range even from a corrupted value
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (ce) begin
         if (hcnt_q >= H_LAST) begin
            hcnt_d = 10'd0;
            if (vcnt_q >= V_LAST) begin
               vcnt_d = 10'd0;
            end else begin
               vcnt_d = vcnt_q + 10'd1;
            end
         end else begin
            hcnt_d = hcnt_q + 10'd1;
         end
      end else begin
         hcnt_d = hcnt_q;
         vcnt_d = vcnt_q;
      end
   end

   // Output decode from the current counters, captured one ce cycle later
   always_comb begin
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      video_on_d    = video_on_q;
      pixel_x_d     = pixel_x_q;
      pixel_y_d     = pixel_y_q;
      line_end_d    = line_end_q;
      frame_start_d = frame_start_q;
      if (ce) begin
         hsync_d       = ((hcnt_q >= HS_START) && (hcnt_q <= HS_END)) ? SYNC_POL : SYNC_OFF;
         vsync_d       = ((vcnt_q >= VS_START) && (vcnt_q <= VS_END)) ? SYNC_POL : SYNC_OFF;
         video_on_d    = (hcnt_q < H_VIS_W) && (vcnt_q < V_VIS_W);
         pixel_x_d     = hcnt_q;
         pixel_y_d     = vcnt_q;
         line_end_d    = (hcnt_q == H_LAST);
         frame_start_d = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
      end else begin
         hsync_d       = hsync_q;
         vsync_d       = vsync_q;
         video_on_d    = video_on_q;
         pixel_x_d     = pixel_x_q;
         pixel_y_d     = pixel_y_q;
         line_end_d    = line_end_q;
         frame_start_d = frame_start_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         hcnt_q        <= 10'd0;
         vcnt_q        <= 10'd0;
         hsync_q       <= SYNC_OFF;
         vsync_q       <= SYNC_OFF;
         video_on_q    <= 1'b0;
         pixel_x_q     <= 10'd0;
         pixel_y_q     <= 10'd0;
         line_end_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
         line_end_q    <= line_end_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign pixel_x     = pixel_x_q;
   assign pixel_y     = pixel_y_q;
   assign line_end    = line_end_q;
   assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       seen_q, seen_d;

   // The first frame_start after reset only arms the counter; later ones count
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      seen_d      = seen_q;
      if (ce && frame_start_d) begin
         if (seen_q) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
         end else begin
            seen_d = 1'b1;
         end
      end else begin
         frame_cnt_d = frame_cnt_q;
         seen_d      = seen_q;
      end
   end

   // Frame counter registers
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         frame_cnt_q <= 8'd0;
         seen_q      <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         seen_q      <= seen_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule
